// File: rtl/rx_symbol_aligner_pkg.sv
// ---------------------------------------------------------------------------
// rx_symbol_aligner_pkg
// Shared definitions for the 8b/10b receive aligner: K28.5 comma code groups
// in both running disparities, the aligner FSM state encoding and a comma
// compare helper that the decoder can reuse.
// ---------------------------------------------------------------------------
package rx_symbol_aligner_pkg;

    localparam int SYM_BITS = 10;

    // K28.5 in abcdeifghj order with 'a' at bit 0 (first bit on the line).
    localparam logic [SYM_BITS-1:0] K28P5_RDN = 10'h17C;
    localparam logic [SYM_BITS-1:0] K28P5_RDP = 10'h283;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_SYNC = 1'b1
    } state_t;

    function automatic logic is_k28p5(input logic [SYM_BITS-1:0] sym);
        return (sym == K28P5_RDN) || (sym == K28P5_RDP);
    endfunction

endpackage

// File: rtl/rx_symbol_aligner_comma_detect.sv
// ---------------------------------------------------------------------------
// comma_detect
// Combinational K28.5 detector for a 10-bit code group (either disparity).
// Ports:
//   sym    in  10  code group, bit 0 = first bit received
//   match  out  1  1 = sym is K28.5 RD- or RD+
// ---------------------------------------------------------------------------
module comma_detect
    import rx_symbol_aligner_pkg::*;
(
    input  logic [SYM_BITS-1:0] sym,
    output logic                match
);

    assign match = is_k28p5(sym);

endmodule

// File: rtl/rx_symbol_aligner.sv
// ---------------------------------------------------------------------------
// rx_symbol_aligner
// Finds K28.5 comma boundaries in the received serial stream and hands
// aligned 10-bit code groups to the decoder, one strobe per symbol. While
// locked it watches the decoder error flag and drops lock after LOSS_ERRORS
// errored symbols with no clean aligned comma in between.
// Parameters:
//   LOSS_ERRORS  errored symbols that force loss of lock (1..15)
//   FILL_BITS    bits accepted after reset before a comma match is honoured
// Ports:
//   INTERCLK      in   1  clock, rising edge
//   RESET         in   1  synchronous active-high reset
//   iSerial       in   1  received line bit
//   iBitValid     in   1  1 = accept iSerial this cycle
//   iDecodeError  in   1  decoder error for the current oData (used when oValid)
//   oData         out 10  aligned code group, bit 0 = first bit received
//   oValid        out  1  one-cycle strobe, oData holds a new symbol
//   oComma        out  1  qualifies oValid, symbol is an aligned K28.5
//   LOCKED        out  1  1 = symbol boundary acquired
// ---------------------------------------------------------------------------
module rx_symbol_aligner
    import rx_symbol_aligner_pkg::*;
#(
    parameter int LOSS_ERRORS = 4,
    parameter int FILL_BITS   = 10
) (
    input  logic                INTERCLK,
    input  logic                RESET,
    input  logic                iSerial,
    input  logic                iBitValid,
    input  logic                iDecodeError,
    output logic [SYM_BITS-1:0] oData,
    output logic                oValid,
    output logic                oComma,
    output logic                LOCKED
);

    localparam int          FILL_W   = $clog2(FILL_BITS + 2);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FILL_BITS);
    localparam logic [3:0]  LAST_BIT = 4'(SYM_BITS - 1);
    localparam logic [3:0]  LOSS_LAST = 4'(LOSS_ERRORS - 1);

    state_t              state, state_nxt;
    logic [SYM_BITS-1:0] sr;
    logic [SYM_BITS-1:0] win;
    logic [FILL_W-1:0]   fill_cnt;
    logic [3:0]          bit_cnt;
    logic [3:0]          err_cnt;
    logic                match;
    logic                fill_done;

    // Control decoded by the FSM for the datapath registers.
    logic emit;
    logic emit_comma;
    logic cnt_clr;
    logic err_clr;
    logic err_inc;

    // New bits enter at the top; the oldest bit of the window sits at bit 0.
    assign win       = {iSerial, sr[SYM_BITS-1:1]};
    assign fill_done = (fill_cnt == FILL_MAX);

    comma_detect u_comma_detect (
        .sym   (win),
        .match (match)
    );

    // -----------------------------------------------------------------------
    // FSM state register. LOCKED tracks the next state so it rises together
    // with the oValid of the locking comma.
    // -----------------------------------------------------------------------
    always_ff @(posedge INTERCLK) begin
        if (RESET) begin
            state  <= ST_HUNT;
            LOCKED <= 1'b0;
        end else begin
            // NOTE: clocked state uses <= so every register samples values from
            // before the edge; blocking = here would create order-dependent races.
            state  <= state_nxt;
            LOCKED <= (state_nxt == ST_SYNC);
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and datapath control.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_nxt  = state;
        emit       = 1'b0;
        emit_comma = 1'b0;
        cnt_clr    = 1'b0;
        err_clr    = 1'b0;
        err_inc    = 1'b0;

        unique case (state)
            ST_HUNT: begin
                if (iBitValid && match && fill_done) begin
                    emit       = 1'b1;
                    emit_comma = 1'b1;
                    cnt_clr    = 1'b1;
                    err_clr    = 1'b1;
                    state_nxt  = ST_SYNC;
                end
            end

            ST_SYNC: begin
                // Only a comma on the locked boundary is flagged; commas at
                // other phases pass through as ordinary bits.
                if (iBitValid && (bit_cnt == LAST_BIT)) begin
                    emit       = 1'b1;
                    emit_comma = match;
                end

                // The decoder flag belongs to the symbol currently on oData.
                // An emit cannot coincide with oValid since the bit counter
                // has just wrapped.
                if (oValid) begin
                    if (iDecodeError) begin
                        if (err_cnt == LOSS_LAST) begin
                            state_nxt = ST_HUNT;
                            emit      = 1'b0;
                            err_clr   = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end else if (oComma) begin
                        err_clr = 1'b1;
                    end
                end
            end

            default: state_nxt = ST_HUNT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Shift register, counters and output registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge INTERCLK) begin
        if (RESET) begin
            // NOTE: the shift register is cleared as well so a partial symbol
            // from before reset can never combine into a false comma.
            sr       <= '0;
            fill_cnt <= '0;
            bit_cnt  <= '0;
            err_cnt  <= '0;
            oData    <= '0;
            oValid   <= 1'b0;
            oComma   <= 1'b0;
        end else begin
            oValid <= emit;
            oComma <= emit_comma;
            if (emit) begin
                oData <= win;
            end

            if (iBitValid) begin
                sr <= win;
                if (!fill_done) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end

            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if ((state == ST_SYNC) && iBitValid) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
            end

            if (err_clr) begin
                err_cnt <= '0;
            end else if (err_inc) begin
                err_cnt <= err_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_symbol_aligner.sv
// ---------------------------------------------------------------------------
// tb_rx_symbol_aligner
// Directed bench for rx_symbol_aligner. Every symbol the bench expects to be
// emitted is queued (data, comma flag, decoder error to return, due cycle)
// at the moment its 10th bit is driven; each oValid pops and compares.
// ---------------------------------------------------------------------------
module tb_rx_symbol_aligner;

    logic       INTERCLK = 1'b0;
    logic       RESET;
    logic       iSerial;
    logic       iBitValid;
    logic       iDecodeError;
    logic [9:0] oData;
    logic       oValid;
    logic       oComma;
    logic       LOCKED;

    rx_symbol_aligner #(
        .LOSS_ERRORS (4),
        .FILL_BITS   (10)
    ) dut (
        .INTERCLK     (INTERCLK),
        .RESET        (RESET),
        .iSerial      (iSerial),
        .iBitValid    (iBitValid),
        .iDecodeError (iDecodeError),
        .oData        (oData),
        .oValid       (oValid),
        .oComma       (oComma),
        .LOCKED       (LOCKED)
    );

    always #5 INTERCLK = ~INTERCLK;

    typedef struct {
        logic [9:0] data;
        logic       comma;
        logic       err;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   last_valid_cyc = 0;
    int   valid_gap = 0;

    function automatic logic is_comma(input logic [9:0] v);
        return (v == 10'h17C) || (v == 10'h283);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Runs at each falling edge: compares any symbol the DUT is presenting
    // and plays the decoder by returning the planned error flag.
    task automatic observe();
        exp_t e;
        iDecodeError = 1'b0;
        if (oValid === 1'b1) begin
            valid_gap      = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(oValid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("data",            32'(oData),  32'(e.data));
                check("comma",           32'(oComma), 32'(e.comma));
                check("locked_on_valid", 32'(LOCKED), 32'd1);
                check("latency",         32'(cyc),    32'(e.due));
                iDecodeError = e.err;
            end
        end
    endtask

    task automatic step(input logic b, input logic v);
        @(negedge INTERCLK);
        cyc++;
        observe();
        iSerial   = b;
        iBitValid = v;
    endtask

    // Sends a symbol LSB (bit a) first, optionally with a stall of
    // stall_len idle cycles before bit stall_at.
    task automatic send_sym(input logic [9:0] s, input logic expect_out, input logic err,
                            input int stall_at, input int stall_len);
        for (int i = 0; i < 10; i++) begin
            if (i == stall_at) begin
                for (int k = 0; k < stall_len; k++) step(1'($urandom), 1'b0);
            end
            step(s[i], 1'b1);
        end
        if (expect_out) begin
            exp_q.push_back('{data: s, comma: is_comma(s), err: err, due: cyc + 1});
        end
    endtask

    task automatic sym(input logic [9:0] s, input logic expect_out, input logic err);
        send_sym(s, expect_out, err, 99, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1);
    endtask

    // Holds RESET for n clock edges with random line activity; every cycle
    // after a reset edge must show all outputs at zero.
    task automatic do_reset(input int n);
        @(negedge INTERCLK);
        cyc++;
        observe();
        RESET     = 1'b1;
        iSerial   = 1'($urandom);
        iBitValid = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            @(negedge INTERCLK);
            cyc++;
            check("rst_odata",  32'(oData),  32'd0);
            check("rst_ovalid", 32'(oValid), 32'd0);
            check("rst_ocomma", 32'(oComma), 32'd0);
            check("rst_locked", 32'(LOCKED), 32'd0);
            iSerial   = 1'($urandom);
            iBitValid = 1'($urandom);
            if (i == n - 1) begin
                RESET     = 1'b0;
                iBitValid = 1'b0;
            end
        end
    endtask

    logic [29:0] phase_stream;
    logic [9:0]  k_rdn;
    int          comma_cyc;

    initial begin
        RESET        = 1'b1;
        iSerial      = 1'b0;
        iBitValid    = 1'b0;
        iDecodeError = 1'b0;
        k_rdn        = 10'h17C;

        // Reset, then 12 zero bits: nothing may be emitted.
        do_reset(2);
        zeros(12);
        check("hunt_after_zeros", 32'(LOCKED), 32'd0);

        // Acquire: 3 junk bits, K28.5 RD-, D21.5.
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        sym(10'h17C, 1'b1, 1'b0);
        sym(10'h155, 1'b1, 1'b0);
        idle(2);
        check("acquire_gap", 32'(valid_gap), 32'd10);
        check("acquire_locked", 32'(LOCKED), 32'd1);

        // Stall: same stream, 5 idle cycles inside the D21.5 symbol.
        do_reset(2);
        zeros(12);
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        sym(10'h17C, 1'b1, 1'b0);
        send_sym(10'h155, 1'b1, 1'b0, 5, 5);
        idle(2);
        check("stall_gap", 32'(valid_gap), 32'd15);

        // RD+ comma, then a K28.5 RD- offset 4 bits from the locked boundary.
        do_reset(2);
        zeros(12);
        sym(10'h283, 1'b1, 1'b0);
        phase_stream = {16'b0101_0101_0101_0101, k_rdn, 4'b0101};
        sym(phase_stream[9:0],   1'b1, 1'b0);
        sym(phase_stream[19:10], 1'b1, 1'b0);
        sym(phase_stream[29:20], 1'b1, 1'b0);
        idle(2);
        check("phase_locked", 32'(LOCKED), 32'd1);

        // Loss: four consecutive errored symbols.
        sym(10'h155, 1'b1, 1'b1);
        sym(10'h155, 1'b1, 1'b1);
        sym(10'h155, 1'b1, 1'b1);
        sym(10'h155, 1'b1, 1'b1);
        idle(1);
        check("locked_before_loss_edge", 32'(LOCKED), 32'd1);
        idle(1);
        check("loss_unlocked", 32'(LOCKED), 32'd0);
        sym(10'h155, 1'b0, 1'b0);
        idle(2);
        check("hunt_no_output", 32'(LOCKED), 32'd0);

        // Relock without refill; errors separated by a clean comma keep lock.
        sym(10'h17C, 1'b1, 1'b0);
        sym(10'h155, 1'b1, 1'b1);
        sym(10'h155, 1'b1, 1'b1);
        sym(10'h155, 1'b1, 1'b1);
        sym(10'h17C, 1'b1, 1'b0);
        sym(10'h155, 1'b1, 1'b1);
        sym(10'h155, 1'b1, 1'b1);
        sym(10'h155, 1'b1, 1'b1);
        sym(10'h155, 1'b1, 1'b0);
        idle(3);
        check("errors_split_locked", 32'(LOCKED), 32'd1);

        // Reset 6 bits into a symbol, then relock needs fill plus a comma.
        for (int i = 0; i < 6; i++) step(1'(i % 2), 1'b1);
        do_reset(1);
        for (int i = 2; i < 10; i++) step(k_rdn[i], 1'b1);
        idle(1);
        check("fill_blocks_early_match", 32'(LOCKED), 32'd0);
        zeros(2);
        comma_cyc = cyc;
        sym(10'h17C, 1'b1, 1'b0);
        idle(2);
        check("relock_after_reset", 32'(LOCKED), 32'd1);
        check("relock_cycle", 32'(last_valid_cyc), 32'(comma_cyc + 11));

        idle(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
